// File: rtl/aperture_ctl_if.sv
// aperture_ctl_if: A8 $D6 write port and page_map request port of aperture_ctl.
// The master side drives the A8 writes and the page_map ready flag; the
// slave side (aperture_ctl) drives the page_map request and status flags.
interface aperture_ctl_if;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       map_valid;
   logic [1:0] map_op;
   logic [7:0] map_from;
   logic [7:0] map_size;
   logic       busy;
   logic       overflow;

   modport master (
      output wr_stb, wr_addr, wr_data, map_valid,
      input  map_op, map_from, map_size, busy, overflow
   );

   modport slave (
      input  wr_stb, wr_addr, wr_data, map_valid,
      output map_op, map_from, map_size, busy, overflow
   );
endinterface

// File: rtl/aperture_ctl.sv
// aperture_ctl: decodes A8 writes to the $D6xx aperture descriptors and
// turns flag commits into OP_ADD / OP_DEL requests for page_map.
// Commits are snapshotted into a small FIFO because page_map is much slower
// than back-to-back A8 writes; a delete is followed by a rescan of all
// enabled apertures so that pages shared with other apertures come back.
module aperture_ctl #(
   parameter int AP_BITS   = 4,
   parameter int FIFO_LOG2 = 2
) (
   input  logic          clk200,
   input  logic          a8_rst,
   aperture_ctl_if.slave bus
);
   localparam int NAP = 1 << AP_BITS;
   localparam int FDEPTH = 1 << FIFO_LOG2;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_DEL  = 2'd2;

   localparam logic [FIFO_LOG2:0]   CNT_ONE  = {{FIFO_LOG2{1'b0}}, 1'b1};
   localparam logic [FIFO_LOG2:0]   CNT_FULL = {1'b1, {FIFO_LOG2{1'b0}}};
   localparam logic [FIFO_LOG2:0]   CNT_ZERO = {(FIFO_LOG2+1){1'b0}};
   localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
   localparam logic [AP_BITS-1:0]   AP_ONE   = AP_BITS'(1);
   localparam logic [AP_BITS-1:0]   AP_LAST  = {AP_BITS{1'b1}};
   localparam logic [AP_BITS-1:0]   AP_ZERO  = {AP_BITS{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_DEL   = 3'd2,
      ST_WAITD = 3'd3,
      ST_WRITE = 3'd4,
      ST_SCAN  = 3'd5,
      ST_ADD   = 3'd6,
      ST_WAITA = 3'd7
   } state_t;

   typedef struct packed {
      logic [AP_BITS-1:0] idx;
      logic [7:0]         from;
      logic [7:0]         size;
      logic               en;
   } entry_t;

   // Pages actually mapped: size clipped so the request never passes page $FF.
   function automatic logic [7:0] eff_size(input logic [7:0] from, input logic [7:0] size);
      logic [8:0] room;
      room = 9'd256 - {1'b0, from};
      if ({1'b0, size} < room) begin
         return size;
      end else begin
         return room[7:0];
      end
   endfunction

   // Staging and active descriptor tables
   logic [7:0]     stg_from_q [NAP];
   logic [7:0]     stg_from_d [NAP];
   logic [7:0]     stg_size_q [NAP];
   logic [7:0]     stg_size_d [NAP];
   logic [7:0]     act_from_q [NAP];
   logic [7:0]     act_from_d [NAP];
   logic [7:0]     act_size_q [NAP];
   logic [7:0]     act_size_d [NAP];
   logic [NAP-1:0] act_en_q, act_en_d;

   // Commit FIFO
   entry_t               fifo_q [FDEPTH];
   entry_t               fifo_d [FDEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG2:0]   cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   // Sequencer
   state_t             state_q, state_d;
   entry_t             e_q, e_d;
   logic               del_done_q, del_done_d;
   logic [AP_BITS-1:0] scan_q, scan_d;
   logic [1:0]         map_op_q, map_op_d;
   logic [7:0]         map_from_q, map_from_d;
   logic [7:0]         map_size_q, map_size_d;
   logic               busy_q, busy_d;

   logic [AP_BITS-1:0] wr_idx_s;
   logic [3:0]         wr_off_s;
   logic               push_req_s, push_ok_s, pop_s;
   entry_t             head_s;
   logic [7:0]         head_old_eff_s, e_eff_s, scan_eff_s;

   assign wr_idx_s       = bus.wr_addr[4 +: AP_BITS];
   assign wr_off_s       = bus.wr_addr[3:0];
   assign head_s         = fifo_q[rd_ptr_q];
   assign head_old_eff_s = eff_size(act_from_q[head_s.idx], act_size_q[head_s.idx]);
   assign e_eff_s        = eff_size(e_q.from, e_q.size);
   assign scan_eff_s     = eff_size(act_from_q[scan_q], act_size_q[scan_q]);
   assign pop_s          = (state_q == ST_POP);

   // Write decode into the staging table and snapshot pushes into the FIFO
   always_comb begin
      stg_from_d = stg_from_q;
      stg_size_d = stg_size_q;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      push_req_s = 1'b0;
      if (bus.wr_stb) begin
         case (wr_off_s)
            4'h4:    stg_from_d[wr_idx_s] = bus.wr_data;
            4'h5:    stg_size_d[wr_idx_s] = bus.wr_data;
            4'hF:    push_req_s = 1'b1;
            default: push_req_s = 1'b0;
         endcase
      end else begin
         push_req_s = 1'b0;
      end
      // a full FIFO still takes a push when its head leaves in the same cycle
      push_ok_s = push_req_s && ((cnt_q != CNT_FULL) || pop_s);
      if (push_ok_s) begin
         fifo_d[wr_ptr_q] = '{idx: wr_idx_s, from: stg_from_q[wr_idx_s],
                              size: stg_size_q[wr_idx_s], en: bus.wr_data[0]};
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else if (push_req_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Commit sequencer: delete old mapping, update active table, add or rescan
   always_comb begin
      state_d    = state_q;
      e_d        = e_q;
      del_done_d = del_done_q;
      scan_d     = scan_q;
      map_op_d   = OP_NONE;
      map_from_d = map_from_q;
      map_size_d = map_size_q;
      act_from_d = act_from_q;
      act_size_d = act_size_q;
      act_en_d   = act_en_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q != CNT_ZERO) begin
               state_d = ST_POP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_POP: begin
            e_d = head_s;
            if (act_en_q[head_s.idx] && (head_old_eff_s != 8'd0)) begin
               map_op_d   = OP_DEL;
               map_from_d = act_from_q[head_s.idx];
               map_size_d = head_old_eff_s;
               del_done_d = 1'b1;
               state_d    = ST_DEL;
            end else begin
               del_done_d = 1'b0;
               state_d    = ST_WRITE;
            end
         end
         ST_DEL:   state_d = ST_WAITD;
         ST_WAITD: begin
            if (bus.map_valid) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_WAITD;
            end
         end
         ST_WRITE: begin
            act_from_d[e_q.idx] = e_q.from;
            act_size_d[e_q.idx] = e_q.size;
            act_en_d[e_q.idx]   = e_q.en;
            if (del_done_q) begin
               scan_d  = AP_ZERO;
               state_d = ST_SCAN;
            end else if (e_q.en && (e_eff_s != 8'd0)) begin
               map_op_d   = OP_ADD;
               map_from_d = e_q.from;
               map_size_d = e_eff_s;
               state_d    = ST_ADD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (act_en_q[scan_q] && (act_size_q[scan_q] != 8'd0)) begin
               map_op_d   = OP_ADD;
               map_from_d = act_from_q[scan_q];
               map_size_d = scan_eff_s;
               state_d    = ST_ADD;
            end else if (scan_q == AP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               scan_d = scan_q + AP_ONE;
            end
         end
         ST_ADD:   state_d = ST_WAITA;
         ST_WAITA: begin
            if (!bus.map_valid) begin
               state_d = ST_WAITA;
            end else if (del_done_q && (scan_q != AP_LAST)) begin
               scan_d  = scan_q + AP_ONE;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE) || (cnt_d != CNT_ZERO);
   end

   // State, tables, FIFO and registered outputs
   always_ff @(posedge clk200 or posedge a8_rst) begin
      if (a8_rst) begin
         stg_from_q <= '{default: 8'h00};
         stg_size_q <= '{default: 8'h00};
         act_from_q <= '{default: 8'h00};
         act_size_q <= '{default: 8'h00};
         act_en_q   <= {NAP{1'b0}};
         fifo_q     <= '{default: '0};
         wr_ptr_q   <= {FIFO_LOG2{1'b0}};
         rd_ptr_q   <= {FIFO_LOG2{1'b0}};
         cnt_q      <= CNT_ZERO;
         ovf_q      <= 1'b0;
         state_q    <= ST_IDLE;
         e_q        <= '0;
         del_done_q <= 1'b0;
         scan_q     <= AP_ZERO;
         map_op_q   <= OP_NONE;
         map_from_q <= 8'h00;
         map_size_q <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         stg_from_q <= stg_from_d;
         stg_size_q <= stg_size_d;
         act_from_q <= act_from_d;
         act_size_q <= act_size_d;
         act_en_q   <= act_en_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         e_q        <= e_d;
         del_done_q <= del_done_d;
         scan_q     <= scan_d;
         map_op_q   <= map_op_d;
         map_from_q <= map_from_d;
         map_size_q <= map_size_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.map_op   = map_op_q;
   assign bus.map_from = map_from_q;
   assign bus.map_size = map_size_q;
   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_aperture_ctl.sv
// tb_aperture_ctl: scoreboard bench for aperture_ctl. Stimulus pushes the
// expected page_map requests into a queue; a monitor pops and compares each
// op pulse. A small page_map stand-in drops map_valid after every request.
`timescale 1ns/100ps
module tb_aperture_ctl;
   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_DEL  = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold_mv = 1'b0;
   logic directed = 1'b0;
   int   total = 0;
   int   bad = 0;

   aperture_ctl_if bus_if();

   aperture_ctl dut (
      .clk200 (clk),
      .a8_rst (rst),
      .bus    (bus_if)
   );

   always #2.5 clk = ~clk;

   // reference model: aperture tables as plain integers
   int m_stg_from [16];
   int m_stg_size [16];
   int m_act_from [16];
   int m_act_size [16];
   bit m_act_en   [16];
   logic [17:0] exp_q [$];

   function automatic int eff(input int f, input int s);
      int room;
      room = 256 - f;
      return (s < room) ? s : room;
   endfunction

   function automatic void exp_op(input logic [1:0] op, input int f, input int s);
      exp_q.push_back({op, 8'(f), 8'(s)});
   endfunction

   function automatic void m_clear();
      for (int k = 0; k < 16; k++) begin
         m_stg_from[k] = 0; m_stg_size[k] = 0;
         m_act_from[k] = 0; m_act_size[k] = 0; m_act_en[k] = 1'b0;
      end
   endfunction

   // what page_map must see for one accepted commit
   function automatic void m_commit(input int i, input bit en);
      bit deleted = 1'b0;
      if (m_act_en[i] && eff(m_act_from[i], m_act_size[i]) != 0) begin
         if (!directed) exp_op(OP_DEL, m_act_from[i], eff(m_act_from[i], m_act_size[i]));
         deleted = 1'b1;
      end
      m_act_from[i] = m_stg_from[i];
      m_act_size[i] = m_stg_size[i];
      m_act_en[i]   = en;
      if (deleted) begin
         for (int k = 0; k < 16; k++)
            if (m_act_en[k] && m_act_size[k] != 0 && !directed)
               exp_op(OP_ADD, m_act_from[k], eff(m_act_from[k], m_act_size[k]));
      end else if (en && eff(m_stg_from[i], m_stg_size[i]) != 0 && !directed) begin
         exp_op(OP_ADD, m_stg_from[i], eff(m_stg_from[i], m_stg_size[i]));
      end
   endfunction

   task automatic wr(input int ap, input int off, input logic [7:0] d);
      @(posedge clk); #1;
      bus_if.wr_stb  = 1'b1;
      bus_if.wr_addr = 8'((ap << 4) | off);
      bus_if.wr_data = d;
      @(posedge clk); #1;
      bus_if.wr_stb  = 1'b0;
   endtask

   // write with model update (commit offsets feed the model)
   task automatic mwr(input int ap, input int off, input logic [7:0] d);
      if (off == 4) m_stg_from[ap] = int'(d);
      else if (off == 5) m_stg_size[ap] = int'(d);
      else if (off == 15) m_commit(ap, d[0]);
      wr(ap, off, d);
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (bus_if.busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, int'(bus_if.busy), 0);
      check({tag, "_pending_ops"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      m_clear();
      exp_q.delete();
   endtask

   // page_map stand-in: not ready for a while after each request
   initial begin
      bus_if.map_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_if.map_valid = 1'b1;
         end else if (hold_mv) begin
            bus_if.map_valid = 1'b0;
         end else if (bus_if.map_op != OP_NONE) begin
            bus_if.map_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            bus_if.map_valid = 1'b1;
         end else begin
            bus_if.map_valid = 1'b1;
         end
      end
   end

   // monitor: every op pulse must match the next expected request
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus_if.map_op != OP_NONE) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_op: got op=%0d from=%h size=%h required no op",
                        bus_if.map_op, bus_if.map_from, bus_if.map_size);
            end else begin
               e = exp_q.pop_front();
               if ({bus_if.map_op, bus_if.map_from, bus_if.map_size} != e) begin
                  bad++;
                  $display("FAIL op_check: got op=%0d from=%h size=%h required op=%0d from=%h size=%h",
                           bus_if.map_op, bus_if.map_from, bus_if.map_size, e[17:16], e[15:8], e[7:0]);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus_if.wr_stb = 1'b0;
      bus_if.wr_addr = 8'h00;
      bus_if.wr_data = 8'h00;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_map_op", int'(bus_if.map_op), 0);
      check("rst_map_from", int'(bus_if.map_from), 0);
      check("rst_map_size", int'(bus_if.map_size), 0);
      check("rst_busy", int'(bus_if.busy), 0);
      check("rst_overflow", int'(bus_if.overflow), 0);
      rst = 1'b0;

      // directed cases with hand-derived expectations
      directed = 1'b1;
      mwr(0, 4, 8'h40); mwr(0, 5, 8'h04);
      exp_op(OP_ADD, 8'h40, 4);
      mwr(0, 15, 8'h01);
      check("t1_busy_set", int'(bus_if.busy), 1);
      wait_idle("t1");
      exp_op(OP_DEL, 8'h40, 4);
      mwr(0, 15, 8'h00);
      wait_idle("t2");
      mwr(1, 4, 8'h40); mwr(1, 5, 8'h08);
      exp_op(OP_ADD, 8'h40, 8);
      mwr(1, 15, 8'h01);
      wait_idle("t3a");
      mwr(2, 4, 8'h44); mwr(2, 5, 8'h04);
      exp_op(OP_ADD, 8'h44, 4);
      mwr(2, 15, 8'h01);
      wait_idle("t3b");
      exp_op(OP_DEL, 8'h40, 8);
      exp_op(OP_ADD, 8'h44, 4);
      mwr(1, 15, 8'h00);
      wait_idle("t3c");
      mwr(3, 4, 8'hF0); mwr(3, 5, 8'h40);
      exp_op(OP_ADD, 8'hF0, 8'h10);
      mwr(3, 15, 8'h01);
      wait_idle("t4a");
      mwr(4, 4, 8'h20); mwr(4, 5, 8'h00);
      mwr(4, 15, 8'h01);
      wait_idle("t4b");
      directed = 1'b0;

      // randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 4)) begin
            int ap = $urandom_range(0, 15);
            int off = $urandom_range(0, 14);
            logic [7:0] d = 8'($urandom_range(0, 255));
            if (off == 5 && $urandom_range(0, 5) == 0) d = 8'h00;
            mwr(ap, off, d);
         end
         n = $urandom_range(1, 3);
         for (int c = 0; c < n; c++)
            mwr($urandom_range(0, 15), 15, 8'({$urandom_range(0, 127), ($urandom_range(0, 3) != 0)}));
         if ($urandom_range(0, 1) == 1)
            mwr($urandom_range(0, 15), 4 + $urandom_range(0, 1), 8'($urandom_range(0, 255)));
         wait_idle("rand");
      end
      check("rand_overflow", int'(bus_if.overflow), 0);

      // FIFO overflow: page_map stalled, six commits
      do_reset();
      for (int k = 0; k < 6; k++) begin
         mwr(k, 4, 8'(16 * (k + 1)));
         mwr(k, 5, 8'h04);
      end
      hold_mv = 1'b1;
      for (int k = 0; k < 5; k++) mwr(k, 15, 8'h01);
      wr(5, 15, 8'h01);
      @(negedge clk);
      check("t5_overflow", int'(bus_if.overflow), 1);
      check("t5_busy", int'(bus_if.busy), 1);
      hold_mv = 1'b0;
      wait_idle("t5");
      check("t5_overflow_sticky", int'(bus_if.overflow), 1);

      // reset while waiting for page_map after an ADD
      hold_mv = 1'b1;
      mwr(7, 4, 8'h10); mwr(7, 5, 8'h02);
      mwr(7, 15, 8'h01);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_add_seen", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_map_op", int'(bus_if.map_op), 0);
      check("t6_map_from", int'(bus_if.map_from), 0);
      check("t6_map_size", int'(bus_if.map_size), 0);
      check("t6_busy", int'(bus_if.busy), 0);
      check("t6_overflow", int'(bus_if.overflow), 0);
      hold_mv = 1'b0;
      m_clear();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("t6_after_busy", int'(bus_if.busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
